load_register: RTL and testbench
================================

Name: load_register

Overview:
- General-purpose, parameterised datapath register. Holds a WIDTH-bit value that can be parallel-loaded, cleared, shifted or counted.
- Used as the storage element for datapath operands and control/status words; several instances share one clock and reset.
- q is always the registered value; no combinational path from d to q.

Parameters:
- WIDTH, 16, bit width of d and q (legal range 1..64).
- RESET_VALUE, 0, value driven on q while reset is asserted and after reset release (WIDTH bits, truncated if wider).

Ports:
- clk  input  1  rising-edge clock; all state changes except reset occur on posedge clk.
- reset  input  1  asynchronous, active-low reset; reset=0 forces q to RESET_VALUE immediately.
- load  input  1  parallel load enable.
- d  input  WIDTH  parallel load data.
- clear  input  1  synchronous clear to zero.
- shift_en  input  1  shift enable.
- shift_dir  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB).
- serial_in  input  1  bit shifted into the vacated position.
- count_en  input  1  counter enable.
- count_up  input  1  1 = increment, 0 = decrement.
- q  output  WIDTH  stored value.
- serial_out  output  1  bit shifted out on the most recent shift; 0 otherwise.
- carry  output  1  registered wrap flag from the most recent count operation.

Behaviour:
- Reset (reset=0, asynchronous): q=RESET_VALUE, serial_out=0, carry=0 immediately, independent of clk. Held while reset=0. On release, first update is at the next posedge clk with reset=1.
- Operation selected at each posedge clk by fixed priority: clear > load > shift_en > count_en > hold.
- clear=1: q<=0; serial_out<=0; carry<=0.
- load=1: q<=d; serial_out<=0; carry<=0. Single-cycle latency: d sampled on the edge, visible on q after it.
- shift_en=1, shift_dir=0: q<={q[WIDTH-2:0],serial_in}; serial_out<=old q[WIDTH-1]. WIDTH=1: q<=serial_in, serial_out<=old q[0].
- shift_en=1, shift_dir=1: q<={serial_in,q[WIDTH-1:1]}; serial_out<=old q[0].
- count_en=1, count_up=1: q<=q+1 modulo 2^WIDTH; carry<=1 only when old q was all ones (wrap to 0), else 0.
- count_en=1, count_up=0: q<=q-1 modulo 2^WIDTH; carry<=1 only when old q was 0 (wrap to all ones), else 0.
- Hold (no enable asserted): q, serial_out and carry keep their values. d changes while load=0 have no effect on q.
- Simultaneous enables: only the highest-priority operation takes effect; lower ones are ignored for that cycle.
- Reset asserted mid-operation: overrides everything asynchronously; the pending operation is discarded.
- X/Z on an enable input is treated as don't-care only in simulation; the implementation must not latch.

Optional Feature:
- Macro REGISTER_PARITY_EN.
- Defined: adds output port parity (1 bit) holding even parity (XOR reduction) of q. It is registered, updated in the same cycle as q, and has a reset value equal to XOR of RESET_VALUE. It is also recomputed on clear (0).
- Undefined: the parity port and logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: reset=0 with d=0, load=0 for 15 ns -> q=0x0000, carry=0, serial_out=0 without waiting for a clock edge. Release reset -> q stays 0x0000.
- Load then hold: load=1, d=0x00AA for one edge -> q=0x00AA. Then load=0, d=0xFFFF for 3 edges -> q remains 0x00AA. Then load=1, d=0x4242 -> q=0x4242.
- Async reset mid-operation: q=0x4242, drive reset=0 between clock edges -> q=0x0000 before the next posedge; load=1 during reset has no effect.
- Priority: q=0x1234, clear=1, load=1, d=0xBEEF -> q=0x0000. Then load=1, shift_en=1, d=0x00FF -> q=0x00FF.
- Shift: q=0x8001, shift left, serial_in=0 -> q=0x0002, serial_out=1. Then shift right, serial_in=1 -> q=0x8001, serial_out=0.
- Count wrap: q=0xFFFF, count up -> q=0x0000, carry=1. Then count down -> q=0xFFFF, carry=1. Then count down -> q=0xFFFE, carry=0. With REGISTER_PARITY_EN, parity=1 at q=0xFFFE.

Source files
------------

// File: rtl/load_register_if.sv
// Bus bundle for load_register: operation controls, load data and registered outputs.
// The parity signal exists only when REGISTER_PARITY_EN is defined.
interface load_register_if #(parameter int WIDTH = 16);
    logic             load;
    logic [WIDTH-1:0] d;
    logic             clear;
    logic             shift_en;
    logic             shift_dir;
    logic             serial_in;
    logic             count_en;
    logic             count_up;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             carry;
`ifdef REGISTER_PARITY_EN
    logic             parity;

    modport master (
        output load, d, clear, shift_en, shift_dir, serial_in, count_en, count_up,
        input  q, serial_out, carry, parity
    );
    modport slave (
        input  load, d, clear, shift_en, shift_dir, serial_in, count_en, count_up,
        output q, serial_out, carry, parity
    );
`else
    modport master (
        output load, d, clear, shift_en, shift_dir, serial_in, count_en, count_up,
        input  q, serial_out, carry
    );
    modport slave (
        input  load, d, clear, shift_en, shift_dir, serial_in, count_en, count_up,
        output q, serial_out, carry
    );
`endif
endinterface

// File: rtl/load_register.sv
// Parameterised datapath register: clear > load > shift > count > hold, async active-low reset.
// Optional registered even-parity output enabled by defining REGISTER_PARITY_EN.
module load_register #(
    parameter int          WIDTH       = 16,
    parameter logic [63:0] RESET_VALUE = 64'h0
) (
    input  logic          clk,
    input  logic          reset,
    load_register_if.slave bus
);

    localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             so_r;
    logic             so_next;
    logic             cy_r;
    logic             cy_next;

    // Shift/count paths written with shift operators and casts so WIDTH=1 stays legal.
    always_comb begin
        q_next  = q_r;
        so_next = so_r;
        cy_next = cy_r;
        if (bus.clear) begin
            q_next  = '0;
            so_next = 1'b0;
            cy_next = 1'b0;
        end else if (bus.load) begin
            q_next  = bus.d;
            so_next = 1'b0;
            cy_next = 1'b0;
        end else if (bus.shift_en) begin
            if (!bus.shift_dir) begin
                q_next  = (q_r << 1) | WIDTH'(bus.serial_in);
                so_next = q_r[WIDTH-1];
            end else begin
                q_next  = (q_r >> 1) | (WIDTH'(bus.serial_in) << (WIDTH-1));
                so_next = q_r[0];
            end
        end else if (bus.count_en) begin
            if (bus.count_up) begin
                q_next  = q_r + WIDTH'(1);
                cy_next = (q_r == '1);
            end else begin
                q_next  = q_r - WIDTH'(1);
                cy_next = (q_r == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r  <= RST_VAL;
            so_r <= 1'b0;
            cy_r <= 1'b0;
        end else begin
            q_r  <= q_next;
            so_r <= so_next;
            cy_r <= cy_next;
        end
    end

    assign bus.q          = q_r;
    assign bus.serial_out = so_r;
    assign bus.carry      = cy_r;

`ifdef REGISTER_PARITY_EN
    logic par_r;

    // Computed from q_next so parity always matches the q it is registered alongside.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_r <= ^RST_VAL;
        end else begin
            par_r <= ^q_next;
        end
    end

    assign bus.parity = par_r;
`endif

endmodule

// File: tb/tb_load_register.sv
// Self-checking bench for load_register: directed plan followed by randomized operations
// compared against an arithmetic reference model.
module tb_load_register;

    localparam int W   = 16;
    localparam int MOD = 65536;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    load_register_if #(.WIDTH(W)) bus ();

    load_register #(.WIDTH(W), .RESET_VALUE(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_q;
    bit m_so;
    bit m_cy;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_parity(input int v);
        int ones = 0;
        for (int i = 0; i < W; i++) ones += (v >> i) & 1;
        return bit'(ones % 2);
    endfunction

    task automatic check_all(input string tag);
        check_val({tag, ".q"}, 64'(bus.q), 64'(m_q));
        check_val({tag, ".serial_out"}, 64'(bus.serial_out), 64'(m_so));
        check_val({tag, ".carry"}, 64'(bus.carry), 64'(m_cy));
`ifdef REGISTER_PARITY_EN
        check_val({tag, ".parity"}, 64'(bus.parity), 64'(ref_parity(m_q)));
`endif
    endtask

    task automatic idle_inputs();
        bus.load      = 1'b0;
        bus.d         = '0;
        bus.clear     = 1'b0;
        bus.shift_en  = 1'b0;
        bus.shift_dir = 1'b0;
        bus.serial_in = 1'b0;
        bus.count_en  = 1'b0;
        bus.count_up  = 1'b0;
    endtask

    task automatic model_reset();
        m_q  = 0;
        m_so = 1'b0;
        m_cy = 1'b0;
    endtask

    // Reference behaviour for one rising edge with reset high.
    task automatic model_edge();
        if (bus.clear) begin
            m_q = 0; m_so = 1'b0; m_cy = 1'b0;
        end else if (bus.load) begin
            m_q = int'(bus.d); m_so = 1'b0; m_cy = 1'b0;
        end else if (bus.shift_en) begin
            if (!bus.shift_dir) begin
                m_so = bit'(m_q / (MOD / 2));
                m_q  = (m_q * 2) % MOD + int'(bus.serial_in);
            end else begin
                m_so = bit'(m_q % 2);
                m_q  = m_q / 2 + int'(bus.serial_in) * (MOD / 2);
            end
        end else if (bus.count_en) begin
            if (bus.count_up) begin
                m_cy = (m_q == MOD - 1);
                m_q  = (m_q + 1) % MOD;
            end else begin
                m_cy = (m_q == 0);
                m_q  = (m_q + MOD - 1) % MOD;
            end
        end
    endtask

    // Inputs are driven at negedge; model follows the posedge; outputs sampled at next negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [W-1:0] v);
        idle_inputs();
        bus.load = 1'b1;
        bus.d    = v;
        cycle();
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();

        #15;
        check_all("reset_held");
        @(negedge clk);
        reset = 1'b1;
        cycle();
        check_all("reset_release");

        do_load(16'h00AA);
        check_all("load_aa");
        bus.d = 16'hFFFF;
        repeat (3) cycle();
        check_all("hold_d_ffff");
        do_load(16'h4242);
        check_all("load_4242");

        // Async reset between edges with load pending.
        bus.load = 1'b1;
        bus.d    = 16'h1111;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset_mid");
        @(posedge clk);
        @(negedge clk);
        check_all("load_during_reset");
        reset = 1'b1;
        idle_inputs();
        cycle();
        check_all("after_async_reset");

        do_load(16'h1234);
        bus.clear = 1'b1; bus.load = 1'b1; bus.d = 16'hBEEF;
        cycle();
        check_all("prio_clear_over_load");
        idle_inputs();
        bus.load = 1'b1; bus.shift_en = 1'b1; bus.d = 16'h00FF;
        cycle();
        check_all("prio_load_over_shift");

        do_load(16'h8001);
        bus.shift_en = 1'b1; bus.shift_dir = 1'b0; bus.serial_in = 1'b0;
        cycle();
        check_val("shl_q", 64'(bus.q), 64'h0002);
        check_val("shl_so", 64'(bus.serial_out), 64'h1);
        bus.shift_dir = 1'b1; bus.serial_in = 1'b1;
        cycle();
        check_val("shr_q", 64'(bus.q), 64'h8001);
        check_val("shr_so", 64'(bus.serial_out), 64'h0);
        idle_inputs();

        do_load(16'hFFFF);
        bus.count_en = 1'b1; bus.count_up = 1'b1;
        cycle();
        check_val("cnt_up_wrap_q", 64'(bus.q), 64'h0000);
        check_val("cnt_up_wrap_carry", 64'(bus.carry), 64'h1);
        bus.count_up = 1'b0;
        cycle();
        check_val("cnt_dn_wrap_q", 64'(bus.q), 64'hFFFF);
        check_val("cnt_dn_wrap_carry", 64'(bus.carry), 64'h1);
        cycle();
        check_val("cnt_dn_q", 64'(bus.q), 64'hFFFE);
        check_val("cnt_dn_carry", 64'(bus.carry), 64'h0);
`ifdef REGISTER_PARITY_EN
        check_val("parity_fffe", 64'(bus.parity), 64'h1);
`endif
        idle_inputs();

        for (int i = 0; i < 600; i++) begin
            bus.clear     = ($urandom_range(0, 15) == 0);
            bus.load      = ($urandom_range(0, 5) == 0);
            bus.d         = W'($urandom);
            bus.shift_en  = ($urandom_range(0, 2) == 0);
            bus.shift_dir = 1'($urandom);
            bus.serial_in = 1'($urandom);
            bus.count_en  = ($urandom_range(0, 1) == 0);
            bus.count_up  = 1'($urandom);
            if (i % 50 == 25) begin
                bus.d = (bus.count_up) ? 16'hFFFF : 16'h0000;
            end
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b0;
                #1;
                model_reset();
                check_all("rand_async_reset");
                @(negedge clk);
                reset = 1'b1;
            end else begin
                cycle();
                check_all("rand_op");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, got running expected finished");
        $fatal(1);
    end

endmodule
